alu_md_controller: RTL and testbench
====================================

Name: alu_md_controller

Overview:
- Decode-stage ALU control for the pipelined RV32 core, generalised to a parametrised control width and the full RV32I ALU op set.
- Adds a sequencer for multi-cycle RV32M operations (mul/div/rem): it detects them, pulses start to the mul/div datapath, counts a fixed latency, stalls decode for that time, then signals completion.
- Sits between the decode logic and the ID/EX register; it drives stallD into the hazard unit.

Parameters:
- CTRL_W, 4, width of ALUControlD; must be >= 4; bits above [3] are always 0.
- MUL_CYCLES, 4, execute latency of mul/mulh/mulhsu/mulhu; must be >= 1.
- DIV_CYCLES, 32, execute latency of div/divu/rem/remu; must be >= 1.
- CNT_W (localparam), clog2(max(MUL_CYCLES,DIV_CYCLES))+1, width of the latency counter.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  the decode-stage instruction is valid (not a bubble).
- flush  in  1  decode/execute flush (taken branch or jump).
- op  in  7  opcode.
- funct3  in  3  funct3 field.
- funct7  in  7  funct7 field.
- ALUControlD  out  CTRL_W  combinational ALU operation select.
- illegalD  out  1  combinational flag: opcode/funct combination is unsupported.
- mdStartE  out  1  registered one-cycle start pulse to the mul/div unit.
- mdFunctE  out  3  registered funct3 of the accepted M-op; held stable until the next accept.
- stallD  out  1  stall request for fetch/decode.
- mdDone  out  1  registered one-cycle pulse: the M-op result is valid.

Behaviour:
- ALUControlD encoding:
  - 0000 add, 0001 sub, 0010 and, 0011 or, 0100 xor.
  - 0101 slt, 0110 sltu, 0111 sll, 1000 srl, 1001 sra.
- Decode rules:
  - R-type (0110011), funct7 0x00: funct3 0..7 map to add, sll, slt, sltu, xor, srl, or, and.
  - R-type, funct7 0x20: funct3 0 is sub, funct3 5 is sra.
  - R-type, funct7 0x01: M-op; ALUControlD = 0000.
  - I-type (0010011): funct3 0..7 map to addi, slli, slti, sltiu, xori, srli/srai, ori, andi.
  - I-type shift immediates: funct3 5 with funct7 0x20 is srai, with funct7 0x00 is srli. slli requires funct7 0x00.
  - Branches (1100011): funct3 0/1 (beq/bne) give sub, 4/5 give slt, 6/7 give sltu.
  - lw, sw, jal, jalr, lui: add.
  - Any other combination: ALUControlD = 0000 and illegalD = 1. illegalD is 0 otherwise.
- mdReq = en & ~flush & (op==0110011) & (funct7==0x01).
- FSM states: IDLE, BUSY, DONE. Counter cnt is CNT_W bits.
- IDLE:
  - stallD = mdReq.
  - On mdReq: latch mdFunctE = funct3; load cnt = LAT-1, where LAT = MUL_CYCLES if funct3[2]==0, else DIV_CYCLES; set mdStartE = 1 next cycle; go to BUSY.
- BUSY:
  - stallD = 1; mdStartE is high only in the first BUSY cycle.
  - If flush: go to IDLE, no mdDone.
  - Else if cnt==0: go to DONE.
  - Else: cnt decrements.
- DONE:
  - mdDone = 1 and stallD = 0, so the stalled M-op leaves decode this cycle.
  - Inputs are ignored; always go to IDLE next.
- Timing for a request at cycle T:
  - stallD high T..T+LAT.
  - mdStartE at T+1.
  - mdDone at T+LAT+1.
- Back-to-back M-ops: the second one is seen in IDLE at T+LAT+2 and is accepted then.
- flush in IDLE suppresses the request (stallD stays 0).
- Reset, including mid-operation: state = IDLE, cnt = 0; mdStartE, mdDone, mdFunctE = 0; stallD = 0 while rst is asserted.
- The mul/div datapath handles divide-by-zero and overflow. The sequencer latency is fixed and data-independent.

Test Plan:
- Decode sweep:
  - R f3=0 f7=0x20 -> 0001.
  - R f3=5 f7=0x20 -> 1001.
  - I f3=5 f7=0x20 -> 1001.
  - I f3=3 -> 0110.
  - bne -> 0001; bltu -> 0110.
  - lw / sw / jalr / lui -> 0000.
  - R f3=0 f7=0x10 -> illegalD = 1, ALUControlD = 0000.
- mul (f3=0) with MUL_CYCLES=4, request at cycle 0:
  - stallD 1 on cycles 0-4.
  - mdStartE on cycle 1, mdFunctE = 0.
  - mdDone on cycle 5 with stallD = 0.
  - Returns to IDLE on cycle 6.
- div (f3=4) with DIV_CYCLES=32 held on the inputs, followed by a rem:
  - First: mdDone at cycle 33.
  - Second accepted at cycle 34, mdStartE at cycle 35, mdFunctE = 6.
- flush at cycle 2 of a div:
  - FSM returns to IDLE, stallD = 0 from cycle 3, no mdDone ever.
  - flush together with mdReq in IDLE -> stallD = 0, no mdStartE.
- rst asserted asynchronously mid-BUSY (between clock edges):
  - Outputs go to 0 immediately.
  - After release, a new mul completes with the full 4-cycle latency.
- en = 0 while the inputs carry an M-op -> stallD = 0, no mdStartE.

Source files
------------

// File: rtl/alu_md_controller.sv
`default_nettype none
// ============================================================================
// Module   : alu_md_controller
// Brief    : Decode-stage ALU control plus fixed-latency RV32M mul/div sequencer.
// Revision : 1.0
// ============================================================================
module alu_md_controller #(
    parameter int CTRL_W     = 4,
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              flush,
    input  logic [6:0]        op,
    input  logic [2:0]        funct3,
    input  logic [6:0]        funct7,
    output logic [CTRL_W-1:0] ALUControlD,
    output logic              illegalD,
    output logic              mdStartE,
    output logic [2:0]        mdFunctE,
    output logic              stallD,
    output logic              mdDone
);

    localparam int MAX_LAT = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(MAX_LAT) + 1;

    localparam logic [CNT_W-1:0] c_mul_load = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_div_load = CNT_W'(DIV_CYCLES - 1);

    localparam logic [6:0] c_op_r    = 7'b0110011;
    localparam logic [6:0] c_op_i    = 7'b0010011;
    localparam logic [6:0] c_op_b    = 7'b1100011;
    localparam logic [6:0] c_op_lw   = 7'b0000011;
    localparam logic [6:0] c_op_sw   = 7'b0100011;
    localparam logic [6:0] c_op_jal  = 7'b1101111;
    localparam logic [6:0] c_op_jalr = 7'b1100111;
    localparam logic [6:0] c_op_lui  = 7'b0110111;

    localparam logic [3:0] c_alu_add  = 4'd0;
    localparam logic [3:0] c_alu_sub  = 4'd1;
    localparam logic [3:0] c_alu_and  = 4'd2;
    localparam logic [3:0] c_alu_or   = 4'd3;
    localparam logic [3:0] c_alu_xor  = 4'd4;
    localparam logic [3:0] c_alu_slt  = 4'd5;
    localparam logic [3:0] c_alu_sltu = 4'd6;
    localparam logic [3:0] c_alu_sll  = 4'd7;
    localparam logic [3:0] c_alu_srl  = 4'd8;
    localparam logic [3:0] c_alu_sra  = 4'd9;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    logic [3:0]       w_alu;
    logic             w_illegal;
    logic             w_md_req;
    logic             w_stall;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       funct_q, funct_d;
    logic             start_q, start_d;
    logic             done_q, done_d;

    // Illegal encodings fall back to add so the datapath sees a harmless op.
    always_comb begin
        w_alu     = c_alu_add;
        w_illegal = 1'b0;
        case (op)
            c_op_r: begin
                if (funct7 == 7'h00) begin
                    case (funct3)
                        3'd1:    w_alu = c_alu_sll;
                        3'd2:    w_alu = c_alu_slt;
                        3'd3:    w_alu = c_alu_sltu;
                        3'd4:    w_alu = c_alu_xor;
                        3'd5:    w_alu = c_alu_srl;
                        3'd6:    w_alu = c_alu_or;
                        3'd7:    w_alu = c_alu_and;
                        default: w_alu = c_alu_add;
                    endcase
                end else if (funct7 == 7'h20 && funct3 == 3'd0) begin
                    w_alu = c_alu_sub;
                end else if (funct7 == 7'h20 && funct3 == 3'd5) begin
                    w_alu = c_alu_sra;
                end else if (funct7 != 7'h01) begin
                    w_illegal = 1'b1;
                end
            end
            c_op_i: begin
                case (funct3)
                    3'd1: begin
                        if (funct7 == 7'h00) w_alu = c_alu_sll;
                        else                 w_illegal = 1'b1;
                    end
                    3'd2:    w_alu = c_alu_slt;
                    3'd3:    w_alu = c_alu_sltu;
                    3'd4:    w_alu = c_alu_xor;
                    3'd5: begin
                        if (funct7 == 7'h00)      w_alu = c_alu_srl;
                        else if (funct7 == 7'h20) w_alu = c_alu_sra;
                        else                      w_illegal = 1'b1;
                    end
                    3'd6:    w_alu = c_alu_or;
                    3'd7:    w_alu = c_alu_and;
                    default: w_alu = c_alu_add;
                endcase
            end
            c_op_b: begin
                case (funct3)
                    3'd0, 3'd1: w_alu = c_alu_sub;
                    3'd4, 3'd5: w_alu = c_alu_slt;
                    3'd6, 3'd7: w_alu = c_alu_sltu;
                    default:    w_illegal = 1'b1;
                endcase
            end
            c_op_lw, c_op_sw: w_illegal = (funct3 != 3'd2);
            c_op_jalr:        w_illegal = (funct3 != 3'd0);
            c_op_jal, c_op_lui: w_illegal = 1'b0;
            default:          w_illegal = 1'b1;
        endcase
        if (w_illegal) w_alu = c_alu_add;
    end

    assign ALUControlD = CTRL_W'(w_alu);
    assign illegalD    = w_illegal;

    assign w_md_req = en & ~flush & (op == c_op_r) & (funct7 == 7'h01);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        funct_d = funct_q;
        start_d = 1'b0;
        done_d  = 1'b0;
        w_stall = 1'b0;
        case (state_q)
            S_IDLE: begin
                w_stall = w_md_req;
                if (w_md_req) begin
                    funct_d = funct3;
                    cnt_d   = funct3[2] ? c_div_load : c_mul_load;
                    start_d = 1'b1;
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                w_stall = 1'b1;
                if (flush) begin
                    state_d = S_IDLE;
                end else if (cnt_q == '0) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            funct_q <= 3'd0;
            start_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            funct_q <= funct_d;
            start_q <= start_d;
            done_q  <= done_d;
        end
    end

    // The stall is combinational from the request, so gate it while in reset.
    assign stallD   = w_stall & ~rst;
    assign mdStartE = start_q;
    assign mdFunctE = funct_q;
    assign mdDone   = done_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_md_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_md_controller
// Brief    : Self-checking bench: decode table, directed M-op timing, random run.
// Revision : 1.0
// ============================================================================
module tb_alu_md_controller;

    localparam int CTRL_W = 4;
    localparam int MUL    = 4;
    localparam int DIV    = 32;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_B    = 7'b1100011;
    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_LUI  = 7'b0110111;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              en = 1'b0;
    logic              flush = 1'b0;
    logic [6:0]        op = 7'd0;
    logic [2:0]        funct3 = 3'd0;
    logic [6:0]        funct7 = 7'd0;
    logic [CTRL_W-1:0] alu_ctrl;
    logic              illegal;
    logic              md_start;
    logic [2:0]        md_funct;
    logic              stall;
    logic              md_done;

    alu_md_controller #(
        .CTRL_W    (CTRL_W),
        .MUL_CYCLES(MUL),
        .DIV_CYCLES(DIV)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .flush      (flush),
        .op         (op),
        .funct3     (funct3),
        .funct7     (funct7),
        .ALUControlD(alu_ctrl),
        .illegalD   (illegal),
        .mdStartE   (md_start),
        .mdFunctE   (md_funct),
        .stallD     (stall),
        .mdDone     (md_done)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Timeline model: an accepted op is described by its accept cycle and latency.
    bit       m_active = 1'b0;
    int       m_tacc   = 0;
    int       m_lat    = 0;
    int       m_funct  = 0;
    int       cyc      = 0;

    int s_alu, s_ill, s_stall, s_start, s_done, s_funct;

    typedef struct {
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        int         alu;
        int         ill;
    } dec_vec_t;

    dec_vec_t dec_tbl[24];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void ref_decode(input logic [6:0] o, input logic [2:0] f3,
                                       input logic [6:0] f7, output int alu, output int ill);
        int rmap[8];
        rmap = '{0, 7, 5, 6, 4, 8, 3, 2};
        alu = 0;
        ill = 0;
        if (o == OP_R) begin
            if (f7 == 7'h00)                   alu = rmap[f3];
            else if (f7 == 7'h20 && f3 == 3'd0) alu = 1;
            else if (f7 == 7'h20 && f3 == 3'd5) alu = 9;
            else if (f7 != 7'h01)               ill = 1;
        end else if (o == OP_I) begin
            if (f3 == 3'd1 && f7 != 7'h00)      ill = 1;
            else if (f3 == 3'd5 && f7 == 7'h20) alu = 9;
            else if (f3 == 3'd5 && f7 != 7'h00) ill = 1;
            else                                alu = rmap[f3];
        end else if (o == OP_B) begin
            if (f3 <= 3'd1)      alu = 1;
            else if (f3 <= 3'd3) ill = 1;
            else if (f3 <= 3'd5) alu = 5;
            else                 alu = 6;
        end else if (o == OP_LW || o == OP_SW) begin
            ill = (f3 != 3'd2) ? 1 : 0;
        end else if (o == OP_JALR) begin
            ill = (f3 != 3'd0) ? 1 : 0;
        end else if (o != OP_JAL && o != OP_LUI) begin
            ill = 1;
        end
        if (ill != 0) alu = 0;
    endfunction

    // Drives one decode cycle (from just after a rising edge), checks it, advances the model.
    task automatic run_cycle(input logic e, input logic fl, input logic [6:0] o,
                             input logic [2:0] f3, input logic [6:0] f7, input string tag);
        int  e_alu, e_ill, rel;
        int  e_stall, e_start, e_done;
        bit  req;
        en = e; flush = fl; op = o; funct3 = f3; funct7 = f7;
        #2;
        s_alu = int'(alu_ctrl); s_ill = int'(illegal); s_stall = int'(stall);
        s_start = int'(md_start); s_done = int'(md_done); s_funct = int'(md_funct);
        ref_decode(o, f3, f7, e_alu, e_ill);
        req = e && !fl && (o == OP_R) && (f7 == 7'h01);
        e_start = 0; e_done = 0; rel = 0;
        if (m_active) begin
            rel = cyc - m_tacc;
            if (rel <= m_lat) begin
                e_stall = 1;
                e_start = (rel == 1) ? 1 : 0;
            end else begin
                e_stall = 0;
                e_done  = 1;
            end
        end else begin
            e_stall = req ? 1 : 0;
        end
        chk({tag, "/alu"},   s_alu,   e_alu);
        chk({tag, "/ill"},   s_ill,   e_ill);
        chk({tag, "/stall"}, s_stall, e_stall);
        chk({tag, "/start"}, s_start, e_start);
        chk({tag, "/done"},  s_done,  e_done);
        chk({tag, "/funct"}, s_funct, m_funct);
        if (m_active) begin
            if (rel > m_lat || fl) m_active = 1'b0;
        end else if (req) begin
            m_active = 1'b1;
            m_tacc   = cyc;
            m_lat    = f3[2] ? DIV : MUL;
            m_funct  = int'(f3);
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        dec_tbl[0]  = '{OP_R,    3'd0, 7'h20, 1, 0};
        dec_tbl[1]  = '{OP_R,    3'd5, 7'h20, 9, 0};
        dec_tbl[2]  = '{OP_I,    3'd5, 7'h20, 9, 0};
        dec_tbl[3]  = '{OP_I,    3'd3, 7'h00, 6, 0};
        dec_tbl[4]  = '{OP_B,    3'd1, 7'h00, 1, 0};
        dec_tbl[5]  = '{OP_B,    3'd6, 7'h00, 6, 0};
        dec_tbl[6]  = '{OP_LW,   3'd2, 7'h00, 0, 0};
        dec_tbl[7]  = '{OP_SW,   3'd2, 7'h00, 0, 0};
        dec_tbl[8]  = '{OP_JALR, 3'd0, 7'h00, 0, 0};
        dec_tbl[9]  = '{OP_LUI,  3'd3, 7'h55, 0, 0};
        dec_tbl[10] = '{OP_R,    3'd0, 7'h10, 0, 1};
        dec_tbl[11] = '{OP_R,    3'd7, 7'h00, 2, 0};
        dec_tbl[12] = '{OP_R,    3'd6, 7'h00, 3, 0};
        dec_tbl[13] = '{OP_R,    3'd4, 7'h00, 4, 0};
        dec_tbl[14] = '{OP_R,    3'd2, 7'h00, 5, 0};
        dec_tbl[15] = '{OP_R,    3'd1, 7'h00, 7, 0};
        dec_tbl[16] = '{OP_R,    3'd5, 7'h00, 8, 0};
        dec_tbl[17] = '{OP_I,    3'd1, 7'h20, 0, 1};
        dec_tbl[18] = '{OP_B,    3'd2, 7'h00, 0, 1};
        dec_tbl[19] = '{OP_R,    3'd3, 7'h01, 0, 0};
        dec_tbl[20] = '{7'h7f,   3'd0, 7'h00, 0, 1};
        dec_tbl[21] = '{OP_JAL,  3'd7, 7'h7f, 0, 0};
        dec_tbl[22] = '{OP_I,    3'd5, 7'h00, 8, 0};
        dec_tbl[23] = '{OP_B,    3'd4, 7'h00, 5, 0};

        // Reset state, with an M-op on the inputs to show stallD is held low.
        #1;
        rst = 1'b1; en = 1'b1; op = OP_R; funct3 = 3'd4; funct7 = 7'h01;
        #2;
        chk("reset/stall", int'(stall), 0);
        chk("reset/start", int'(md_start), 0);
        chk("reset/done",  int'(md_done), 0);
        chk("reset/funct", int'(md_funct), 0);
        en = 1'b0;
        #9 rst = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 24; i++) begin
            run_cycle(1'b0, 1'b0, dec_tbl[i].op, dec_tbl[i].f3, dec_tbl[i].f7, "dec");
            chk($sformatf("dec_tbl[%0d]/alu", i), s_alu, dec_tbl[i].alu);
            chk($sformatf("dec_tbl[%0d]/ill", i), s_ill, dec_tbl[i].ill);
        end

        // mul at k=0, div accepted at k=6, rem accepted at k=40; inputs held while stalled.
        for (int k = 0; k < 80; k++) begin
            logic       e;
            logic [2:0] f;
            if (k <= 5)       begin e = 1'b1; f = 3'd0; end
            else if (k <= 39) begin e = 1'b1; f = 3'd4; end
            else if (k <= 73) begin e = 1'b1; f = 3'd6; end
            else              begin e = 1'b0; f = 3'd0; end
            run_cycle(e, 1'b0, OP_R, f, 7'h01, "seq_md");
            if (k <= 4) chk("mul_stall", s_stall, 1);
            if (k == 1) begin chk("mul_start", s_start, 1); chk("mul_funct", s_funct, 0); end
            if (k == 5) begin chk("mul_done", s_done, 1); chk("mul_done_stall", s_stall, 0); end
            if (k == 6) chk("div_accept", s_stall, 1);
            if (k == 7) chk("div_funct", s_funct, 4);
            if (k == 38) chk("div_done_early", s_done, 0);
            if (k == 39) begin chk("div_done", s_done, 1); chk("div_done_stall", s_stall, 0); end
            if (k == 40) chk("rem_accept", s_stall, 1);
            if (k == 41) begin chk("rem_start", s_start, 1); chk("rem_funct", s_funct, 6); end
            if (k == 73) chk("rem_done", s_done, 1);
        end

        // Flush on the second busy cycle of a div.
        begin
            int dones;
            dones = 0;
            for (int k = 0; k <= 40; k++) begin
                run_cycle((k <= 2), (k == 2), OP_R, 3'd4, 7'h01, "flush_busy");
                if (k >= 3) chk("flush_stall", s_stall, 0);
                dones += s_done;
            end
            chk("flush_no_done", dones, 0);
        end
        run_cycle(1'b1, 1'b1, OP_R, 3'd0, 7'h01, "flush_idle");
        chk("flush_idle_stall", s_stall, 0);
        run_cycle(1'b0, 1'b0, OP_R, 3'd0, 7'h01, "flush_idle2");
        chk("flush_idle_start", s_start, 0);

        run_cycle(1'b0, 1'b0, OP_R, 3'd5, 7'h01, "en0");
        chk("en0_stall", s_stall, 0);
        run_cycle(1'b0, 1'b0, OP_R, 3'd5, 7'h01, "en0b");
        chk("en0_start", s_start, 0);

        // Asynchronous reset in the middle of a div.
        for (int k = 0; k < 6; k++) run_cycle(1'b1, 1'b0, OP_R, 3'd4, 7'h01, "pre_rst");
        #2 rst = 1'b1;
        #1;
        chk("async_rst/stall", int'(stall), 0);
        chk("async_rst/start", int'(md_start), 0);
        chk("async_rst/done",  int'(md_done), 0);
        chk("async_rst/funct", int'(md_funct), 0);
        m_active = 1'b0;
        m_funct  = 0;
        en = 1'b0;
        @(posedge clk);
        #3 rst = 1'b0;
        @(posedge clk);
        #1;
        begin
            int dones;
            dones = 0;
            for (int k = 0; k <= 6; k++) begin
                run_cycle((k <= 5), 1'b0, OP_R, 3'd1, 7'h01, "post_rst");
                if (k <= 4) begin chk("post_rst_stall", s_stall, 1); dones += s_done; end
                if (k == 1) chk("post_rst_start", s_start, 1);
                if (k == 5) chk("post_rst_done", s_done, 1);
            end
            chk("post_rst_no_early_done", dones, 0);
        end

        // Random traffic against the timeline model.
        for (int n = 0; n < 1500; n++) begin
            logic       e, fl;
            logic [6:0] o, f7;
            logic [2:0] f3;
            int         r;
            r  = $urandom_range(0, 9);
            e  = ($urandom_range(0, 3) != 0);
            fl = ($urandom_range(0, 15) == 0);
            f3 = 3'($urandom_range(0, 7));
            f7 = 7'($urandom_range(0, 127));
            o  = OP_R;
            case (r)
                0, 1, 2, 3: f7 = 7'h01;
                4:          f7 = ($urandom_range(0, 1) != 0) ? 7'h20 : f7;
                5:          begin o = OP_I; if ($urandom_range(0, 1) != 0) f7 = 7'h00; end
                6:          o = OP_B;
                7: begin
                    case ($urandom_range(0, 4))
                        0:       o = OP_LW;
                        1:       o = OP_SW;
                        2:       o = OP_JAL;
                        3:       o = OP_JALR;
                        default: o = OP_LUI;
                    endcase
                end
                8:          o = 7'($urandom_range(0, 127));
                default:    f7 = 7'h00;
            endcase
            run_cycle(e, fl, o, f3, f7, "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
